// File: rtl/stream_demux_pkg.sv
// Shared lane count, select width and select type for the 1-to-4 stream distributor.
package stream_demux_pkg;

  localparam int N_LANES = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice for a single lane, with its delivered-word counter.
module demux_slot #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  logic              valid_reg;
  logic              valid_next;
  logic [DATA_W-1:0] data_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              pop;

  assign pop = valid_reg & out_ready;

  // The top only loads when the slot is empty or draining this edge,
  // so a load always leaves the slot full.
  always_comb begin
    valid_next = valid_reg;
    if (load) begin
      valid_next = 1'b1;
    end else if (pop) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      if (load) begin
        data_reg <= load_data;
      end
      if (pop) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign count     = count_reg;

endmodule

// File: rtl/stream_demux_1_to_4.sv
// Registered 1-to-4 stream distributor: steers each accepted word into the slot picked by in_sel.
module stream_demux_1_to_4
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  lane_sel_t                 in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_LANES*DATA_W-1:0] out_data,
  output logic [N_LANES-1:0]        out_valid,
  input  logic [N_LANES-1:0]        out_ready,
  output logic [N_LANES*CNT_W-1:0]  lane_count,
  output logic                      busy
);

  logic                accept;
  logic [N_LANES-1:0]  load;

  // Only the addressed lane can stall the input; it frees up if it pops this edge.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign busy     = |out_valid;

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      assign load[gi] = accept && (in_sel == lane_sel_t'(gi));

      demux_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (load[gi]),
        .load_data (in_data),
        .out_ready (out_ready[gi]),
        .out_valid (out_valid[gi]),
        .out_data  (out_data[gi*DATA_W +: DATA_W]),
        .count     (lane_count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux_1_to_4.sv
// Directed and random checks of stream_demux_1_to_4 against a per-lane queue model.
module tb_stream_demux_1_to_4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] lane_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Model: each lane is a queue of words awaiting delivery, plus a delivered count.
  logic [7:0] mq [4][$];
  int         mcnt [4];
  int         model_pops = 0;
  int         dut_pops   = 0;
  bit         hold_src   = 0;
  logic [7:0] held_data;
  logic [1:0] held_sel;
  bit         chk_en     = 0;

  stream_demux_1_to_4 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lane_count (lane_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model update on each edge, also asserting the source-stability rule.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        mcnt[k] = 0;
      end
      hold_src = 0;
    end else begin
      bit exp_rdy;
      bit acc;
      if (hold_src && in_valid) begin
        chk("src_data_stable", {24'd0, in_data}, {24'd0, held_data});
        chk("src_sel_stable", {30'd0, in_sel}, {30'd0, held_sel});
      end
      exp_rdy   = (mq[in_sel].size() == 0) || out_ready[in_sel];
      acc       = in_valid && exp_rdy;
      hold_src  = in_valid && !exp_rdy;
      held_data = in_data;
      held_sel  = in_sel;
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0 && out_ready[k]) begin
          void'(mq[k].pop_front());
          mcnt[k] = (mcnt[k] + 1) % 256;
          model_pops++;
        end
      end
      if (acc) mq[in_sel].push_back(in_data);
    end
  end

  // Compare process: every cycle, mid-period, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      bit any_full;
      bit exp_rdy;
      any_full = 0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("lane%0d_valid", k), {31'd0, out_valid[k]}, {31'd0, mq[k].size() != 0});
        if (mq[k].size() != 0) begin
          any_full = 1;
          chk($sformatf("lane%0d_data", k), {24'd0, out_data[k*8 +: 8]}, {24'd0, mq[k][0]});
        end
        chk($sformatf("lane%0d_count", k), {24'd0, lane_count[k*8 +: 8]}, mcnt[k]);
        if (out_valid[k] && out_ready[k]) dut_pops++;
      end
      exp_rdy = (mq[in_sel].size() == 0) || out_ready[in_sel];
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("busy", {31'd0, busy}, {31'd0, any_full});
    end
  end

  initial begin
    reset     = 1'b1;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #12;
    reset  = 1'b0;
    chk_en = 1;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_lane_count", lane_count, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single word to lane 2 with lane 2 ready.
    @(posedge clk); #1;
    in_data = 8'hA5; in_sel = 2'd2; in_valid = 1'b1; out_ready = 4'b0100;
    #1 chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("t2_valid", {28'd0, out_valid}, 32'h4);
    chk("t2_data", {24'd0, out_data[23:16]}, 32'hA5);
    step();
    chk("t2_valid_after", {28'd0, out_valid}, 32'h0);
    chk("t2_counts", lane_count, 32'h0001_0000);

    // Backpressure on lane 1; lane 3 still flows.
    out_ready = 4'b0000;
    in_data = 8'h11; in_sel = 2'd1; in_valid = 1'b1;
    step();
    in_data = 8'h22; in_sel = 2'd1;
    #1 chk("t3_stall_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("t3_lane1_hold", {24'd0, out_data[15:8]}, 32'h11);
    in_valid = 1'b0;
    step();
    in_data = 8'h33; in_sel = 2'd3; in_valid = 1'b1;
    #1 chk("t3_lane3_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("t3_valid", {28'd0, out_valid}, 32'hA);
    in_data = 8'h22; in_sel = 2'd1; out_ready = 4'b0010;
    #1 chk("t3_unstall_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("t3_lane1_new", {24'd0, out_data[15:8]}, 32'h22);
    chk("t3_lane1_cnt", {24'd0, lane_count[15:8]}, 32'd1);
    out_ready = 4'b1010;
    step();
    chk("t3_drained", {28'd0, out_valid}, 32'h0);
    chk("t3_counts", lane_count, 32'h0101_0200);

    // Load and pop on the same edge of lane 0.
    out_ready = 4'b0000;
    in_data = 8'h01; in_sel = 2'd0; in_valid = 1'b1;
    step();
    in_data = 8'h02; out_ready = 4'b0001;
    #1 chk("t4_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("t4_valid", {28'd0, out_valid}, 32'h1);
    chk("t4_data", {24'd0, out_data[7:0]}, 32'h02);
    chk("t4_cnt", {24'd0, lane_count[7:0]}, 32'd1);
    step();
    chk("t4_cnt2", {24'd0, lane_count[7:0]}, 32'd2);

    // Asynchronous reset asserted while the clock is high, with a word held.
    out_ready = 4'b0000;
    in_data = 8'h5C; in_sel = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("t1_async_valid", {28'd0, out_valid}, 32'h0);
    chk("t1_async_count", lane_count, 32'h0);
    chk("t1_async_busy", {31'd0, busy}, 32'd0);
    #3 reset = 1'b0;
    step();
    chk("t1_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_rel_busy", {31'd0, busy}, 32'd0);

    // 256 words through lane 3 wrap its counter back to zero.
    out_ready = 4'b1000; in_sel = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("t5_cnt_255", {24'd0, lane_count[31:24]}, 32'd255);
    step();
    chk("t5_wrap", lane_count, 32'h0);

    // Random stress; the stimulus holds data/sel while the model says it is stalled.
    for (int c = 0; c < 10000; c++) begin
      if (!hold_src) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 8'($urandom);
      end
      out_ready = 4'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    step();
    step();
    chk("stress_total_pops", dut_pops, model_pops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
